// File: rtl/uart_port_if.sv
// CPU-side bus of uart_port: TX write strobe/byte, RX pop strobe and RX status.
interface uart_port_if;
  logic       uart_wr;
  logic [7:0] uart_w;
  logic       uart_rd;
  logic       uart_busy;
  logic       uart_valid;
  logic [7:0] uart_data;
  logic       uart_overrun;

  modport master (
    output uart_wr, uart_w, uart_rd,
    input  uart_busy, uart_valid, uart_data, uart_overrun
  );

  modport slave (
    input  uart_wr, uart_w, uart_rd,
    output uart_busy, uart_valid, uart_data, uart_overrun
  );
endinterface

// File: rtl/uart_port.sv
// uart_port: 8N1 UART with independent TX and RX, DIVISOR clocks per bit.
// Build option: define UART_PORT_RX_FIFO_EN for an 8-entry RX FIFO; otherwise
// received bytes go to a single holding register.
//
// TX and RX state machines share one state encoding:
//   state   | meaning
//   S_IDLE  | line idle, waiting for a write (TX) or a falling edge (RX)
//   S_START | start bit: TX drives 0 / RX waits to mid-start and re-checks
//   S_DATA  | 8 data bits, LSB first, tracked by a 3-bit bit index
//   S_STOP  | stop bit: TX drives 1 / RX samples it at mid-bit
module uart_port #(
  parameter int unsigned DIVISOR = 104
) (
  input  logic        clk,
  input  logic        resetq,
  uart_port_if.slave  bus,
  input  logic        rx,
  output logic        tx
);

  localparam logic [15:0] BIT_LAST  = 16'(DIVISOR - 1);
  localparam logic [15:0] HALF_LAST = 16'((DIVISOR / 2) - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t      tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_idx;
  logic [7:0]  tx_sh;
  logic        tx_busy;

  state_t      rx_state;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_idx;
  logic [7:0]  rx_sh;
  logic        rx_s1, rx_s2, rx_prev;
  logic        rx_push;
  logic        pop;

  // TX frame sequencer; writes are only looked at in S_IDLE, so a write
  // during a frame is dropped without touching the shift register.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_sh    <= '0;
      tx_busy  <= 1'b0;
      tx       <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (bus.uart_wr) begin
            tx_sh    <= bus.uart_w;
            tx_cnt   <= BIT_LAST;
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt == 16'd0) begin
            tx_cnt   <= BIT_LAST;
            tx       <= tx_sh[0];
            tx_sh    <= {1'b0, tx_sh[7:1]};
            tx_idx   <= 3'd0;
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (tx_cnt == 16'd0) begin
            tx_cnt <= BIT_LAST;
            if (tx_idx == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              tx     <= tx_sh[0];
              tx_sh  <= {1'b0, tx_sh[7:1]};
              tx_idx <= tx_idx + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (tx_cnt == 16'd0) begin
            tx_busy  <= 1'b0;
            tx_state <= S_IDLE;
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  assign bus.uart_busy = tx_busy;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // RX frame sequencer. Arming needs a high-to-low edge, so after a framing
  // error the line must return high before a new start is recognised.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_sh    <= '0;
    end else begin
      case (rx_state)
        S_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= HALF_LAST;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt == 16'd0) begin
            if (rx_s2) begin
              rx_state <= S_IDLE;
            end else begin
              rx_cnt   <= BIT_LAST;
              rx_idx   <= 3'd0;
              rx_state <= S_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (rx_cnt == 16'd0) begin
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_cnt <= BIT_LAST;
            if (rx_idx == 3'd7) begin
              rx_state <= S_STOP;
            end else begin
              rx_idx <= rx_idx + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (rx_cnt == 16'd0) begin
            rx_state <= S_IDLE;
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // A good stop bit delivers rx_sh to storage; a low stop bit is discarded.
  assign rx_push = (rx_state == S_STOP) && (rx_cnt == 16'd0) && rx_s2;
  assign pop     = bus.uart_rd && bus.uart_valid;

`ifdef UART_PORT_RX_FIFO_EN
  logic [7:0] mem [8];
  logic [2:0] wp, rp;
  logic [3:0] count;
  logic       ovr;
  logic       push_ok;

  // A pop in the same cycle frees the slot, so push always wins then.
  assign push_ok = rx_push && ((count != 4'd8) || pop);

  // RX FIFO: pointers, occupancy and the overrun pulse.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovr   <= 1'b0;
    end else begin
      ovr <= rx_push && !push_ok;
      if (push_ok) begin
        mem[wp] <= rx_sh;
        wp      <= wp + 3'd1;
      end
      if (pop) rp <= rp + 3'd1;
      case ({push_ok, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  assign bus.uart_valid   = (count != 4'd0);
  assign bus.uart_data    = bus.uart_valid ? mem[rp] : 8'h00;
  assign bus.uart_overrun = ovr;
`else
  logic [7:0] hold;
  logic       hold_valid;
  logic       ovr;

  // Single holding register; cleared on pop so uart_data reads 0 when empty.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      ovr        <= 1'b0;
    end else begin
      ovr <= 1'b0;
      if (rx_push) begin
        if (!hold_valid || pop) begin
          hold       <= rx_sh;
          hold_valid <= 1'b1;
        end else begin
          ovr <= 1'b1;
        end
      end else if (pop) begin
        hold       <= '0;
        hold_valid <= 1'b0;
      end
    end
  end

  assign bus.uart_valid   = hold_valid;
  assign bus.uart_data    = hold;
  assign bus.uart_overrun = ovr;
`endif

endmodule

// File: tb/tb_uart_port.sv
// Directed bench for uart_port at DIVISOR=4. Inputs change on the falling
// edge, outputs are sampled on the falling edge.
module tb_uart_port;
  localparam int DIV = 4;

  logic clk;
  logic resetq;
  logic rx;
  logic tx;
  int   checks;
  int   failures;
  int   ov_cnt;
  int   ov0;
  int   busy_cycles;
  logic [9:0] f1, f2;
  logic etx, ebusy;

  uart_port_if bus ();

  uart_port #(.DIVISOR(DIV)) dut (
    .clk    (clk),
    .resetq (resetq),
    .bus    (bus),
    .rx     (rx),
    .tx     (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.uart_overrun === 1'b1) ov_cnt++;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
  endtask

  task automatic pop_byte(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, 16'(bus.uart_valid), 16'd1);
    chk({tag, "_data"}, 16'(bus.uart_data), 16'(exp));
    bus.uart_rd = 1'b1;
    @(negedge clk);
    bus.uart_rd = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    ov_cnt = 0;
    rx = 1'b1;
    resetq = 1'b0;
    bus.uart_wr = 1'b0;
    bus.uart_w = 8'h00;
    bus.uart_rd = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 16'(tx), 16'd1);
    chk("rst_busy", 16'(bus.uart_busy), 16'd0);
    chk("rst_valid", 16'(bus.uart_valid), 16'd0);
    chk("rst_data", 16'(bus.uart_data), 16'd0);
    chk("rst_overrun", 16'(bus.uart_overrun), 16'd0);
    resetq = 1'b1;
    repeat (2) @(negedge clk);

    // TX: 0xA5, an ignored 0x3C mid-frame, then 0x0F on the first idle cycle
    f1 = {1'b1, 8'hA5, 1'b0};
    f2 = {1'b1, 8'h0F, 1'b0};
    busy_cycles = 0;
    bus.uart_wr = 1'b1;
    bus.uart_w = 8'hA5;
    @(negedge clk);
    bus.uart_wr = 1'b0;
    for (int n = 0; n < 85; n++) begin
      if (n < 40) begin
        etx = f1[n / 4]; ebusy = 1'b1;
      end else if (n == 40) begin
        etx = 1'b1; ebusy = 1'b0;
      end else if (n < 81) begin
        etx = f2[(n - 41) / 4]; ebusy = 1'b1;
      end else begin
        etx = 1'b1; ebusy = 1'b0;
      end
      chk($sformatf("tx_n%0d", n), 16'(tx), 16'(etx));
      chk($sformatf("busy_n%0d", n), 16'(bus.uart_busy), 16'(ebusy));
      if (n <= 40 && bus.uart_busy === 1'b1) busy_cycles++;
      if (n == 5)  begin bus.uart_wr = 1'b1; bus.uart_w = 8'h3C; end
      if (n == 6)  bus.uart_wr = 1'b0;
      if (n == 40) begin bus.uart_wr = 1'b1; bus.uart_w = 8'h0F; end
      if (n == 41) bus.uart_wr = 1'b0;
      @(negedge clk);
    end
    chk("busy_cycles", 16'(busy_cycles), 16'd40);

    // RX: one good frame, then pop
    ov0 = ov_cnt;
    send_frame(8'h5A, 1'b1);
    pop_byte("rx5a", 8'h5A);
    chk("rx5a_after_valid", 16'(bus.uart_valid), 16'd0);
    chk("rx5a_after_data", 16'(bus.uart_data), 16'd0);

    // Pop while empty has no effect
    bus.uart_rd = 1'b1;
    @(negedge clk);
    bus.uart_rd = 1'b0;
    chk("empty_rd_valid", 16'(bus.uart_valid), 16'd0);

    // One-clock glitch is a false start
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (12 * DIV) @(negedge clk);
    chk("glitch_valid", 16'(bus.uart_valid), 16'd0);

    // Framing error discards, the next good frame is received
    send_frame(8'h33, 1'b0);
    chk("frame_err_valid", 16'(bus.uart_valid), 16'd0);
    send_frame(8'h77, 1'b1);
    pop_byte("rx77", 8'h77);
    chk("rx_no_overrun", 16'(ov_cnt - ov0), 16'd0);

    // Overrun
    ov0 = ov_cnt;
`ifdef UART_PORT_RX_FIFO_EN
    for (int v = 1; v <= 8; v++) send_frame(8'(v), 1'b1);
    chk("fifo8_overrun", 16'(ov_cnt - ov0), 16'd0);
    send_frame(8'h09, 1'b1);
    chk("fifo9_overrun", 16'(ov_cnt - ov0), 16'd1);
    for (int v = 1; v <= 8; v++) pop_byte($sformatf("fifo_rd%0d", v), 8'(v));
    chk("fifo_empty_valid", 16'(bus.uart_valid), 16'd0);
    chk("fifo_empty_data", 16'(bus.uart_data), 16'd0);
`else
    send_frame(8'h01, 1'b1);
    chk("hold1_overrun", 16'(ov_cnt - ov0), 16'd0);
    send_frame(8'h02, 1'b1);
    chk("hold2_overrun", 16'(ov_cnt - ov0), 16'd1);
    pop_byte("hold_rd", 8'h01);
    chk("hold_empty_valid", 16'(bus.uart_valid), 16'd0);
    chk("hold_empty_data", 16'(bus.uart_data), 16'd0);
`endif

    // Reset mid-TX and mid-RX with a byte pending
    send_frame(8'h11, 1'b1);
    chk("pre_rst_valid", 16'(bus.uart_valid), 16'd1);
    bus.uart_wr = 1'b1;
    bus.uart_w = 8'h00;
    @(negedge clk);
    bus.uart_wr = 1'b0;
    rx = 1'b0;
    repeat (15) @(negedge clk);
    chk("mid_busy", 16'(bus.uart_busy), 16'd1);
    chk("mid_tx", 16'(tx), 16'd0);
    resetq = 1'b0;
    #1;
    chk("arst_tx", 16'(tx), 16'd1);
    chk("arst_busy", 16'(bus.uart_busy), 16'd0);
    chk("arst_valid", 16'(bus.uart_valid), 16'd0);
    chk("arst_data", 16'(bus.uart_data), 16'd0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    resetq = 1'b1;
    ov0 = ov_cnt;
    repeat (60) @(negedge clk);
    chk("post_rst_valid", 16'(bus.uart_valid), 16'd0);
    chk("post_rst_busy", 16'(bus.uart_busy), 16'd0);
    chk("post_rst_tx", 16'(tx), 16'd1);
    chk("post_rst_overrun", 16'(ov_cnt - ov0), 16'd0);
    send_frame(8'hC3, 1'b1);
    pop_byte("post_rst_rx", 8'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_port.md
UART_PORT -- requirements
Module: uart_port

Interface
REQ-001 SHALL have parameter DIVISOR, default 104, meaning clocks per serial bit; legal values are 4 to 65535.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port resetq, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port uart_wr, input, 1 bit: CPU write strobe, a one-cycle TX request.
REQ-005 SHALL have port uart_w, input, 8 bits: TX byte, sampled on the uart_wr cycle.
REQ-006 SHALL have port uart_rd, input, 1 bit: CPU read strobe, a one-cycle RX pop.
REQ-007 SHALL have port uart_busy, output, 1 bit: transmitter occupied.
REQ-008 SHALL have port uart_valid, output, 1 bit: at least one received byte is available.
REQ-009 SHALL have port uart_data, output, 8 bits: oldest received byte; it equals 0 when uart_valid=0.
REQ-010 SHALL have port uart_overrun, output, 1 bit: one-cycle pulse when a received byte is dropped.
REQ-011 SHALL have port rx, input, 1 bit: asynchronous serial input, idle high.
REQ-012 SHALL have port tx, output, 1 bit: serial output, idle high.

Function
REQ-013 SHALL use a 8N1 frame: one start bit (0), data bits LSB first, one stop bit (1); each bit lasts DIVISOR clocks.
REQ-014 SHALL, on uart_wr=1 while uart_busy=0, latch uart_w; uart_busy=1 and tx=0 from the next cycle.
REQ-015 SHALL ignore uart_wr while uart_busy=1: no latch, and the frame in progress is unaffected.
REQ-016 SHALL drop uart_busy in the cycle after the last stop-bit clock, so a frame occupies 10*DIVISOR busy cycles.
REQ-017 SHALL accept a uart_wr in the first cycle busy=0 and start the next frame with no idle gap beyond that cycle.
REQ-018 SHALL use a TX state machine with states IDLE -> START -> DATA(bit index 0..7) -> STOP -> IDLE, and a down-counter reloaded to DIVISOR-1 at each bit.
REQ-019 SHALL pass rx through a two-flop synchronizer before any use.
REQ-020 SHALL use an RX state machine with states IDLE, START, DATA, STOP.
REQ-021 SHALL move from RX IDLE to START when the synchronized rx falls.
REQ-022 SHALL, in START, wait DIVISOR/2 (integer division) clocks and then resample; if rx=1 it is a false start and SHALL return to IDLE with no push.
REQ-023 SHALL sample each of the 8 data bits every DIVISOR clocks from the mid-start point.
REQ-024 SHALL push the byte if the stop-bit sample is 1; if it is 0 (framing error) it SHALL discard the byte and return to IDLE.
REQ-025 SHALL wait in IDLE for rx=1 before arming for a new start after a framing error.
REQ-026 SHALL, on uart_rd=1 while uart_valid=1, pop the oldest byte; uart_data/uart_valid update the next cycle.
REQ-027 SHALL ignore uart_rd while uart_valid=0.
REQ-028 SHALL, on a push when storage is full and no same-cycle pop, drop the new byte, keep stored bytes unchanged, and pulse uart_overrun for 1 cycle.
REQ-029 SHALL, on a push and a pop in the same cycle, always succeed for both, with occupancy unchanged.
REQ-030 SHALL keep TX and RX fully independent; loopback of tx to rx SHALL work.

Reset
REQ-031 SHALL, on resetq=0, immediately set tx=1, uart_busy=0, uart_valid=0, uart_data=0 and uart_overrun=0.
REQ-032 SHALL, on resetq=0, clear both state machines to IDLE and clear counters, storage and pointers, including mid-frame.
REQ-033 SHALL abandon a partial frame on reset with no push afterwards; the partially sent TX frame is truncated with tx high.

Configuration
REQ-034 SHALL provide macro UART_PORT_RX_FIFO_EN; when defined, RX storage SHALL be an 8-entry FIFO of 3-bit pointers plus a 4-bit count, with full at count=8.
REQ-035 SHALL, when UART_PORT_RX_FIFO_EN is undefined, use a single holding register, full while uart_valid=1; REQ-028/029 still apply.

Verification (DIVISOR=4)
REQ-036 SHALL cover TX: uart_wr with 0xA5 -> tx line reads 0,1,0,1,0,0,1,0,1,1 at 4 clocks each, with uart_busy high exactly 40 cycles.
REQ-037 SHALL cover TX with uart_wr 0x3C during busy -> ignored, tx waveform unchanged, and a second write accepted on the first busy=0 cycle.
REQ-038 SHALL cover RX: drive a frame carrying 0x5A on rx -> uart_valid=1 with uart_data=0x5A; uart_rd -> uart_valid=0 and uart_data=0 the next cycle.
REQ-039 SHALL cover rx low for 1 clock only -> no push; a frame whose stop bit is 0 -> no push, uart_valid stays 0.
REQ-040 SHALL cover FIFO build: 9 frames 0x01..0x09 with no reads -> 8 bytes stored, overrun pulses once on 0x09, and reads return 0x01..0x08; with no FIFO, 2 frames -> 0x01 kept, overrun pulses once.
REQ-041 SHALL cover resetq low mid-TX and mid-RX -> tx=1, busy=0, valid=0 at once, with no spurious byte after reset is released.
